// File: rtl/ls00_quad_nand_bist.sv
// Built-in self-test sequencer for the ls00_quad_nand quad 2-input NAND block.
// Applies four rotating input vectors to all gates, checks the outputs and reports pass/fail.
module ls00_quad_nand_bist #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a1,
    output logic       b1,
    output logic       a2,
    output logic       b2,
    output logic       a3,
    output logic       b3,
    output logic       a4,
    output logic       b4,
    input  logic       y1,
    input  logic       y2,
    input  logic       y3,
    input  logic       y4,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic [3:0] fail_mask
);

    // Settle counter is 4 bits, enough for SETTLE_CYCLES in 1..15.
    localparam logic [3:0] CntReload = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StApply,
        StCheck,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  v_q, v_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [4:0]  err_q, err_d;
    logic [3:0]  mask_q, mask_d;
    logic [7:0]  ab_q, ab_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;

    logic [3:0]  y_vec;
    logic [3:0]  exp_vec;
    logic [3:0]  mism;
    logic [2:0]  mism_cnt;

    // Gate g (0-based) gets {a,b} = (v + g) mod 4, packed as ab[2g+1]=a, ab[2g]=b.
    function automatic logic [7:0] vec_for(input logic [1:0] v);
        logic [7:0] vec;
        vec = '0;
        for (int g = 0; g < 4; g++) begin
            vec[2*g +: 2] = v + 2'(g);
        end
        return vec;
    endfunction

    assign y_vec = {y4, y3, y2, y1};

    // Case inequality so that X/Z on a returned output is flagged in simulation.
    always_comb begin
        exp_vec = '0;
        mism    = '0;
        for (int g = 0; g < 4; g++) begin
            exp_vec[g] = ~(ab_q[2*g+1] & ab_q[2*g]);
            mism[g]    = (y_vec[g] !== exp_vec[g]);
        end
        mism_cnt = 3'(mism[0]) + 3'(mism[1]) + 3'(mism[2]) + 3'(mism[3]);
    end

    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        mask_d  = mask_q;
        ab_d    = ab_q;

        unique case (state_q)
            StIdle: begin
                ab_d = '0;
                if (start) begin
                    state_d = StApply;
                    v_d     = 2'd0;
                    cnt_d   = CntReload;
                    err_d   = '0;
                    mask_d  = '0;
                    ab_d    = vec_for(2'd0);
                end
            end
            StApply: begin
                if (cnt_q == 4'd0) begin
                    state_d = StCheck;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StCheck: begin
                err_d  = err_q + {2'b00, mism_cnt};
                mask_d = mask_q | mism;
                if (v_q == 2'd3) begin
                    state_d = StDone;
                end else begin
                    state_d = StApply;
                    v_d     = v_q + 2'd1;
                    cnt_d   = CntReload;
                    ab_d    = vec_for(v_q + 2'd1);
                end
            end
            StDone: begin
                // Last vector stays driven; a new start behaves exactly as from idle.
                if (start) begin
                    state_d = StApply;
                    v_d     = 2'd0;
                    cnt_d   = CntReload;
                    err_d   = '0;
                    mask_d  = '0;
                    ab_d    = vec_for(2'd0);
                end
            end
            default: begin
                state_d = StIdle;
                ab_d    = '0;
            end
        endcase

        busy_d = (state_d == StApply) || (state_d == StCheck);
        done_d = (state_d == StDone);
        pass_d = done_d && (err_d == 5'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            v_q     <= 2'd0;
            cnt_q   <= 4'd0;
            err_q   <= 5'd0;
            mask_q  <= 4'd0;
            ab_q    <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            mask_q  <= mask_d;
            ab_q    <= ab_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign {a1, b1} = ab_q[1:0];
    assign {a2, b2} = ab_q[3:2];
    assign {a3, b3} = ab_q[5:4];
    assign {a4, b4} = ab_q[7:6];

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_mask = mask_q;

endmodule

// File: tb/tb_ls00_quad_nand_bist.sv
// Bench for ls00_quad_nand_bist: a NAND gate model with injectable truth-table faults
// and a reference model that derives expected results from the fault table.
module tb_ls00_quad_nand_bist;

    localparam int S     = 2;
    localparam int TOTAL = 4 * (S + 1);

    logic       clk;
    logic       rst;
    logic       start;
    wire  [3:0] a_w;
    wire  [3:0] b_w;
    logic [3:0] y_w;
    wire        busy;
    wire        done;
    wire        pass;
    wire  [4:0] err_count;
    wire  [3:0] fail_mask;

    // flip[4*g + {a,b}] inverts gate g's output for that input combination.
    logic [15:0] flip;

    int tests_run;
    int tests_failed;

    ls00_quad_nand_bist #(.SETTLE_CYCLES(S)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a1       (a_w[0]),
        .b1       (b_w[0]),
        .a2       (a_w[1]),
        .b2       (b_w[1]),
        .a3       (a_w[2]),
        .b3       (b_w[2]),
        .a4       (a_w[3]),
        .b4       (b_w[3]),
        .y1       (y_w[0]),
        .y2       (y_w[1]),
        .y3       (y_w[2]),
        .y4       (y_w[3]),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_count(err_count),
        .fail_mask(fail_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        y_w = '0;
        for (int g = 0; g < 4; g++) begin
            int idx;
            idx = 4 * g + 2 * int'(a_w[g]) + int'(b_w[g]);
            y_w[g] = ~(a_w[g] & b_w[g]) ^ flip[idx];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Every gate sees every combination once, so each corrupted table entry is one mismatch.
    function automatic void model_run(input logic [15:0] f, output int err, output logic [3:0] mask);
        err  = 0;
        mask = '0;
        for (int g = 0; g < 4; g++) begin
            for (int c = 0; c < 4; c++) begin
                bit good, obs;
                good = !(c == 3);
                obs  = good ^ f[4*g+c];
                if (obs != good) begin
                    err++;
                    mask[g] = 1'b1;
                end
            end
        end
    endfunction

    function automatic logic [3:0] stuck_flip(input bit val);
        logic [3:0] r;
        for (int c = 0; c < 4; c++) r[c] = ((!(c == 3)) != val);
        return r;
    endfunction

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < 200) begin
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        flip  = '0;
        tick();
        tick();
        rst = 1'b0;
        tests_run++;
        if ({a_w, b_w} !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_ab: got %b_%b want 0000_0000", a_w, b_w);
        end
        tests_run++;
        if ({busy, done, pass} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_flags: busy/done/pass got %b%b%b want 000", busy, done, pass);
        end
        tests_run++;
        if (err_count !== 5'd0 || fail_mask !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_counts: err %0d mask %b want 0 0000", err_count, fail_mask);
        end
    endtask

    task automatic test_vector_sequence();
        flip = '0;
        start_run();
        for (int e = 0; e <= TOTAL; e++) begin
            int v;
            logic [3:0] ea, eb;
            v = e / (S + 1);
            if (v > 3) v = 3;
            for (int g = 0; g < 4; g++) begin
                int c;
                c = (v + g) % 4;
                ea[g] = (c >= 2);
                eb[g] = (c % 2 == 1);
            end
            tests_run++;
            if (a_w !== ea || b_w !== eb || busy !== (e < TOTAL) || done !== (e == TOTAL)) begin
                tests_failed++;
                $display("FAIL seq_edge%0d: a %b b %b busy %b done %b want a %b b %b busy %b done %b",
                         e, a_w, b_w, busy, done, ea, eb, e < TOTAL, e == TOTAL);
            end
            if (e < TOTAL) tick();
        end
        tests_run++;
        if (pass !== 1'b1 || err_count !== 5'd0 || fail_mask !== 4'd0) begin
            tests_failed++;
            $display("FAIL seq_result: pass %b err %0d mask %b want 1 0 0000",
                     pass, err_count, fail_mask);
        end
    endtask

    task automatic test_stuck_faults();
        logic [15:0] fl [3];
        int          ee [3];
        logic [3:0]  em [3];
        int          cycles;
        fl[0] = {4'b0, stuck_flip(1'b1), 8'b0};
        ee[0] = 1;  em[0] = 4'b0100;
        fl[1] = {12'b0, stuck_flip(1'b0)};
        ee[1] = 3;  em[1] = 4'b0001;
        fl[2] = {4{stuck_flip(1'b0)}};
        ee[2] = 12; em[2] = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            flip = fl[i];
            start_run();
            wait_done(cycles);
            tests_run++;
            if (cycles != TOTAL) begin
                tests_failed++;
                $display("FAIL stuck%0d_latency: got %0d want %0d", i, cycles, TOTAL);
            end
            tests_run++;
            if (err_count !== 5'(ee[i]) || fail_mask !== em[i] || pass !== 1'b0) begin
                tests_failed++;
                $display("FAIL stuck%0d_result: err %0d mask %b pass %b want %0d %b 0",
                         i, err_count, fail_mask, pass, ee[i], em[i]);
            end
        end
        flip = '0;
    endtask

    task automatic test_random_faults();
        int         cycles;
        int         exp_err;
        logic [3:0] exp_mask;
        for (int i = 0; i < 10; i++) begin
            flip = 16'($urandom);
            if (i == 0) flip = '0;
            model_run(flip, exp_err, exp_mask);
            start_run();
            wait_done(cycles);
            tests_run++;
            if (cycles != TOTAL || err_count !== 5'(exp_err) || fail_mask !== exp_mask
                || pass !== (exp_err == 0)) begin
                tests_failed++;
                $display("FAIL rand%0d flip %h: cyc %0d err %0d mask %b pass %b want %0d %0d %b %b",
                         i, flip, cycles, err_count, fail_mask, pass, TOTAL, exp_err, exp_mask,
                         exp_err == 0);
            end
        end
        flip = '0;
    endtask

    task automatic test_start_ignored();
        flip = '0;
        start_run();
        for (int e = 0; e < TOTAL; e++) begin
            start = (e == 2 || e == 6);
            tick();
            start = 1'b0;
            tests_run++;
            if (done !== (e + 1 == TOTAL)) begin
                tests_failed++;
                $display("FAIL ignore_edge%0d: done %b want %b", e + 1, done, e + 1 == TOTAL);
            end
        end
        tests_run++;
        if (pass !== 1'b1 || err_count !== 5'd0) begin
            tests_failed++;
            $display("FAIL ignore_result: pass %b err %0d want 1 0", pass, err_count);
        end
    endtask

    task automatic test_reset_mid_run();
        int cycles;
        flip = {4'b0, stuck_flip(1'b1), 8'b0};
        start_run();
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if ({a_w, b_w, busy, done, pass, err_count, fail_mask} !== '0) begin
            tests_failed++;
            $display("FAIL midrst_outputs: ab %b_%b busy %b done %b pass %b err %0d mask %b want all 0",
                     a_w, b_w, busy, done, pass, err_count, fail_mask);
        end
        flip = '0;
        tick();
        tests_run++;
        if (busy !== 1'b0 || {a_w, b_w} !== 8'h00) begin
            tests_failed++;
            $display("FAIL midrst_idle: busy %b ab %b_%b want 0 0000_0000", busy, a_w, b_w);
        end
        start_run();
        wait_done(cycles);
        tests_run++;
        if (cycles != TOTAL || pass !== 1'b1 || err_count !== 5'd0) begin
            tests_failed++;
            $display("FAIL midrst_rerun: cyc %0d pass %b err %0d want %0d 1 0",
                     cycles, pass, err_count, TOTAL);
        end
    endtask

    task automatic test_back_to_back();
        int cycles;
        flip = {4'b0, stuck_flip(1'b1), 8'b0};
        start_run();
        wait_done(cycles);
        tests_run++;
        if (err_count !== 5'd1 || fail_mask !== 4'b0100) begin
            tests_failed++;
            $display("FAIL b2b_first: err %0d mask %b want 1 0100", err_count, fail_mask);
        end
        flip = '0;
        start_run();
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b1 || err_count !== 5'd0 || fail_mask !== 4'd0) begin
            tests_failed++;
            $display("FAIL b2b_restart: done %b busy %b err %0d mask %b want 0 1 0 0000",
                     done, busy, err_count, fail_mask);
        end
        wait_done(cycles);
        tests_run++;
        if (cycles != TOTAL || pass !== 1'b1 || err_count !== 5'd0 || fail_mask !== 4'd0) begin
            tests_failed++;
            $display("FAIL b2b_second: cyc %0d pass %b err %0d mask %b want %0d 1 0 0000",
                     cycles, pass, err_count, fail_mask, TOTAL);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        start        = 1'b0;
        flip         = '0;
        test_reset();
        test_vector_sequence();
        test_stuck_faults();
        test_random_faults();
        test_start_ignored();
        test_reset_mid_run();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
